// File: rtl/spi_peripheral.sv
// Memory-mapped SPI peripheral (mode 0, 8-bit, MSB first) with STATUS/CONTROL/DATA registers.
// SPI pins are asynchronous to clk and are synchronized before use.
module spi_peripheral #(
    parameter logic [31:0] ADDR = 32'hd100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    localparam logic [31:0] STATUS_A  = ADDR;
    localparam logic [31:0] CONTROL_A = ADDR + 32'd4;
    localparam logic [31:0] DATA_A    = ADDR + 32'd8;

    typedef enum logic {
        IDLE     = 1'b0,
        SELECTED = 1'b1
    } state_t;

    state_t              state;
    logic                enable;
    logic [BYTE_W-1:0]   tx_buf;
    logic                tx_full;
    logic [BYTE_W-1:0]   rx_data;
    logic                rx_valid;
    logic                overrun;
    logic                frame_err;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BYTE_W-1:0]   tx_shift;
    logic [BYTE_W-1:0]   rx_shift;

    logic [2:0]          sclk_q;
    logic [2:0]          cs_q;
    logic [1:0]          mosi_q;

    logic                sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                status_wr, control_wr, data_wr, data_rd;
    logic                cs_active;
    logic [BYTE_W-1:0]   rx_next;
    logic [BYTE_W-1:0]   tx_reload;
    logic                unused_bits;

    // Two-flop synchronizers; the third flop on sclk/cs_n gives edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    assign status_wr  = wen && wmask[0] && (addr == STATUS_A);
    assign control_wr = wen && wmask[0] && (addr == CONTROL_A);
    assign data_wr    = wen && wmask[0] && (addr == DATA_A);
    assign data_rd    = ren && (addr == DATA_A);

    assign cs_active = (state == SELECTED);
    assign rx_next   = {rx_shift[BYTE_W-2:0], mosi_q[1]};
    assign tx_reload = tx_full ? tx_buf : 8'h00;

    assign ready  = 1'b1;
    assign active = (addr == STATUS_A) || (addr == CONTROL_A) || (addr == DATA_A);
    assign miso   = cs_active & tx_shift[BYTE_W-1];

    assign unused_bits = ^{wdata[31:8], wdata[7:5], wdata[3], wdata[1], wmask[3:1], rx_shift[BYTE_W-1]};

    // Combinational register read mux.
    always_comb begin
        rdata = 32'h0;
        if (addr == STATUS_A)
            rdata = {27'b0, frame_err, cs_active, overrun, tx_full, rx_valid};
        else if (addr == CONTROL_A)
            rdata = {31'b0, enable};
        else if (addr == DATA_A)
            rdata = {16'b0, rx_data, tx_buf};
    end

    // Bus register writes and the SPI framing state machine; later assignments take priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            enable    <= 1'b0;
            tx_buf    <= '0;
            tx_full   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
        end else begin
            if (data_rd)
                rx_valid <= 1'b0;
            if (status_wr) begin
                if (wdata[2]) overrun   <= 1'b0;
                if (wdata[4]) frame_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable && cs_fall) begin
                        state    <= SELECTED;
                        bit_cnt  <= '0;
                        tx_shift <= tx_reload;
                        tx_full  <= 1'b0;
                    end
                end
                SELECTED: begin
                    if (!enable) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (cs_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        if (bit_cnt != '0)
                            frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            if (rx_valid && !data_rd)
                                overrun <= 1'b1;
                            bit_cnt  <= '0;
                            tx_shift <= tx_reload;
                            tx_full  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase

            if (control_wr)
                enable <= wdata[0];
            if (data_wr) begin
                tx_buf  <= wdata[BYTE_W-1:0];
                tx_full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 The block SHALL have parameter ADDR, default 32'hd100, the base address of its three 32-bit registers.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports addr input 32, wdata input 32, wmask input 4, wen input 1, ren input 1: the bus request.
REQ-005 The block SHALL have ports rdata output 32, ready output 1, active output 1: the bus response.
REQ-006 The block SHALL have ports sclk input 1, cs_n input 1, mosi input 1, all asynchronous to clk, from the external SPI controller.
REQ-007 The block SHALL have port miso, output, 1 bit: serial data to the controller.

Function
REQ-010 Registers SHALL be: STATUS = ADDR+0, CONTROL = ADDR+4, DATA = ADDR+8.
REQ-011 active SHALL be 1 exactly when addr matches one of the three registers; ready SHALL be constant 1.
REQ-012 rdata SHALL be combinational: STATUS = {27'b0, frame_err, cs_active, overrun, tx_full, rx_valid}; CONTROL = {31'b0, enable}; DATA = {16'b0, rx_data, tx_buf}; any other address = 0.
REQ-013 A CONTROL write with wmask[0] SHALL load enable from wdata[0].
REQ-014 A DATA write with wmask[0] SHALL load tx_buf from wdata[7:0] and set tx_full.
REQ-015 A STATUS write with wmask[0] SHALL clear overrun where wdata[2]=1 and frame_err where wdata[4]=1 (write-1-to-clear); all other STATUS bits are read-only.
REQ-016 A cycle with ren=1 and addr=DATA SHALL clear rx_valid on the next edge.
REQ-017 sclk, cs_n and mosi SHALL each pass through a 2-flop synchronizer; a third flop on sclk and on cs_n SHALL provide edge detection.
REQ-018 The protocol SHALL be mode 0, 8-bit bytes, MSB first: mosi is sampled on the synchronized sclk rising edge, and miso changes on the synchronized falling edge.
REQ-019 The supported sclk frequency SHALL be at most clk/8.
REQ-020 The state machine SHALL have two states, IDLE and SELECTED; cs_active = (state==SELECTED).
REQ-021 IDLE to SELECTED SHALL occur on a synchronized cs_n falling edge while enable=1.
  - bit_cnt <= 0.
  - tx_shift <= tx_buf if tx_full, else 8'h00.
  - tx_full <= 0.
REQ-022 In SELECTED, each sclk rising edge SHALL do rx_shift <= {rx_shift[6:0], mosi} and bit_cnt++.
REQ-023 On the 8th rising edge (byte complete):
  - rx_data <= the completed byte; rx_valid <= 1.
  - overrun <= 1 if rx_valid was already 1 and was not being cleared in the same cycle.
  - bit_cnt <= 0.
  - tx_shift is reloaded per REQ-021 and tx_full is cleared.
REQ-024 In SELECTED, an sclk falling edge with bit_cnt != 0 SHALL shift tx_shift left by one, filling with 0; with bit_cnt == 0 it SHALL leave tx_shift unchanged.
REQ-025 miso SHALL be tx_shift[7] in SELECTED and 0 in IDLE.
REQ-026 A cs_n rising edge in SELECTED SHALL return the block to IDLE.
  - If bit_cnt != 0: discard the partial byte and set frame_err; rx_data and rx_valid are unchanged.
REQ-027 enable=0 SHALL force IDLE on the next edge (frame_err not set); cs_n falling edges SHALL be ignored while enable=0.
REQ-028 Simultaneous events:
  - Byte complete and DATA read in the same cycle: the completion wins, so rx_valid stays 1 with no overrun.
  - Reload and DATA write in the same cycle: the reload uses the old tx_buf/tx_full state, then the write sets tx_buf and tx_full=1.

Reset
REQ-030 With rst_n=0 at a clk edge, all of the following SHALL be 0 and the state SHALL be IDLE:
  - enable, tx_buf, tx_full, rx_data, rx_valid, overrun, frame_err, bit_cnt, tx_shift, rx_shift.
  - Synchronizer flops are set to sclk=0, cs_n=1.
REQ-031 After reset, miso SHALL be 0; a reset mid-byte SHALL abort the byte without setting frame_err.

Verification
REQ-040 Setup: enable=1, write DATA=0xA5, controller sends 0x3C at clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; STATUS=0x1; tx_full=0.
REQ-041 Two bytes 0x11, 0x22 with no DATA read in between -> rx_data=0x22; rx_valid=1; overrun=1; writing STATUS=0x4 clears overrun.
REQ-042 cs_n rises after 5 bits -> frame_err=1; rx_valid unchanged; state IDLE; the next full byte is received correctly.
REQ-043 A byte with tx_full=0 -> miso all zeros; a DATA write landing on the reload cycle -> the value is sent in the following byte.
REQ-044 A DATA read in the byte-complete cycle -> rx_valid=1, overrun=0. Also: enable=0 or rst_n=0 mid-byte -> IDLE, miso=0, frame_err=0.
